// File: rtl/msg_scroll14.sv
// rtl/msg_scroll14.sv - ASCII message buffer with scrolling and 14-segment
// encoding for a 12-digit display scanner; segm is registered one cycle after dig_idx.
module msg_scroll14 #(
  parameter int MAX_LEN    = 32,
  parameter int SCROLL_DIV = 50000
) (
`ifdef USE_POWER_PINS
  inout  wire        vdd,
  inout  wire        vss,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  input  logic       scroll_en,
  input  logic [3:0] dig_idx,
  output logic [13:0] segm,
  output logic [5:0] msg_len
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [5:0]    LAST_IDX  = 6'(MAX_LEN - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, SHOW = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [MAX_LEN];
  logic [5:0]    wr_ptr_q, len_q, offset_q;
  logic [TW-1:0] timer_q;
  logic [13:0]   segm_q, segm_d;

  logic          accept, wr_end, blank;
  logic [5:0]    wr_idx, wr_cnt;
  logic [6:0]    sum, pos;

  function automatic logic [13:0] enc(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": enc = 14'b1110111_1100000;
      "B": enc = 14'b1111000_1010010;
      "C": enc = 14'b1001110_0000000;
      "D": enc = 14'b1111000_0010010;
      "E": enc = 14'b1001111_0000000;
      "F": enc = 14'b1000111_0000000;
      "G": enc = 14'b1011110_1000000;
      "H": enc = 14'b0110111_1100000;
      "I": enc = 14'b1001000_0010010;
      "J": enc = 14'b0111100_0000000;
      "K": enc = 14'b0000111_0001001;
      "L": enc = 14'b0001110_0000000;
      "M": enc = 14'b0110110_0101000;
      "N": enc = 14'b0110110_0100001;
      "O": enc = 14'b1111110_0000000;
      "P": enc = 14'b1100111_1000000;
      "Q": enc = 14'b1111110_0000001;
      "R": enc = 14'b1100111_1000001;
      "S": enc = 14'b1011011_1000000;
      "T": enc = 14'b1000000_0010010;
      "U": enc = 14'b0111110_0000000;
      "V": enc = 14'b0000110_0001100;
      "W": enc = 14'b0110110_0000101;
      "X": enc = 14'b0000000_0101101;
      "Y": enc = 14'b0000000_0101010;
      "Z": enc = 14'b1001000_0001100;
      "0": enc = 14'b1111110_0001100;
      "1": enc = 14'b0110000_0001000;
      "2": enc = 14'b1101101_1000000;
      "3": enc = 14'b1111000_1000000;
      "4": enc = 14'b0110011_1000000;
      "5": enc = 14'b1011011_1000000;
      "6": enc = 14'b1011111_1000000;
      "7": enc = 14'b1110000_0000000;
      "8": enc = 14'b1111111_1000000;
      "9": enc = 14'b1111011_1000000;
      default: enc = 14'b0;
    endcase
  endfunction

  assign wr_ready = 1'b1;
  assign accept   = wr_valid & wr_ready;
  assign segm     = segm_q;
  assign msg_len  = len_q;

  // A write outside LOAD always restarts the message at index 0.
  always_comb begin
    wr_idx = (state_q == LOAD) ? wr_ptr_q : 6'd0;
    wr_cnt = wr_idx + 6'd1;
    wr_end = wr_last || (wr_idx == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = wr_end ? SHOW : LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx[AW-1:0]] <= wr_char;
  end

  // Ring of msg_len characters plus one blank separator; one subtraction
  // suffices because scrolling only happens when msg_len exceeds the digit count.
  always_comb begin
    sum    = {1'b0, offset_q} + {3'b0, dig_idx};
    pos    = (sum > {1'b0, len_q}) ? sum - ({1'b0, len_q} + 7'd1) : sum;
    blank  = (state_q != SHOW) || (dig_idx > 4'd11) ||
             ((len_q <= 6'd12) && ({2'b0, dig_idx} >= len_q)) ||
             (pos == {1'b0, len_q});
    segm_d = blank ? 14'b0 : enc(mem[pos[AW-1:0]]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segm_q   <= '0;
      len_q    <= '0;
      wr_ptr_q <= '0;
      offset_q <= '0;
      timer_q  <= '0;
    end else begin
      segm_q <= segm_d;
      if (accept) begin
        wr_ptr_q <= wr_cnt;
        len_q    <= wr_end ? wr_cnt : 6'd0;
        offset_q <= '0;
        timer_q  <= '0;
      end else if (state_q == SHOW && len_q > 6'd12 && scroll_en) begin
        if (timer_q == TIMER_MAX) begin
          timer_q  <= '0;
          offset_q <= (offset_q == len_q) ? 6'd0 : offset_q + 6'd1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_msg_scroll14.sv
// tb/tb_msg_scroll14.sv - directed self-checking bench for msg_scroll14
// (MAX_LEN=32, SCROLL_DIV=4).
module tb_msg_scroll14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_char = 8'h00;
  logic        wr_last = 1'b0;
  logic        scroll_en = 1'b0;
  logic [3:0]  dig_idx = 4'd0;
  logic [13:0] segm;
  logic [5:0]  msg_len;

  int checks = 0;
  int failures = 0;

  localparam logic [13:0] SEG_E = 14'b10011110000000;
  localparam logic [13:0] SEG_L = 14'b00011100000000;
  localparam logic [13:0] SEG_O = 14'b11111100000000;
  localparam logic [13:0] SEG_S = 14'b10110111000000;
  localparam logic [13:0] SEG_T = 14'b10000000010010;
  localparam logic [31:0] ST_EMPTY = 32'd0;
  localparam logic [31:0] ST_LOAD  = 32'd1;
  localparam logic [31:0] ST_SHOW  = 32'd2;

  msg_scroll14 #(.MAX_LEN(32), .SCROLL_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .scroll_en(scroll_en),
    .dig_idx(dig_idx), .segm(segm), .msg_len(msg_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] c, input logic last);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Test messages cycle through "ELOST", even positions written in lowercase.
  function automatic logic [7:0] char_of(input int k);
    string s;
    logic [7:0] c;
    s = "ELOST";
    c = s[k % 5];
    if (k % 2 == 0) c = c + 8'h20;
    return c;
  endfunction

  function automatic logic [13:0] seg_of(input int k);
    case (k % 5)
      0: return SEG_E;
      1: return SEG_L;
      2: return SEG_O;
      3: return SEG_S;
      default: return SEG_T;
    endcase
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_segm", 32'(segm), 32'd0);
    check("rst_async_len", 32'(msg_len), 32'd0);
    check("rst_state", 32'(dut.state_q), ST_EMPTY);
    check("wr_ready", 32'(wr_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    dig_idx = 4'd0;
    tick();
    check("idle_segm", 32'(segm), 32'd0);

    put(8'h65, 1'b0);
    check("el_len_load", 32'(msg_len), 32'd0);
    check("el_state_load", 32'(dut.state_q), ST_LOAD);
    put(8'h6C, 1'b1);
    check("el_len", 32'(msg_len), 32'd2);
    check("el_state_show", 32'(dut.state_q), ST_SHOW);
    dig_idx = 4'd0; tick(); check("el_d0", 32'(segm), 32'(SEG_E));
    dig_idx = 4'd1; tick(); check("el_d1", 32'(segm), 32'(SEG_L));
    dig_idx = 4'd2; tick(); check("el_d2", 32'(segm), 32'd0);
    dig_idx = 4'd13; tick(); check("el_d13", 32'(segm), 32'd0);

    for (int k = 0; k < 14; k++) put(char_of(k), k == 13);
    check("scr_len", 32'(msg_len), 32'd14);
    dig_idx = 4'd11;
    repeat (3) tick();
    check("scr_hold_timer", 32'(dut.timer_q), 32'd0);
    check("scr_hold_off", 32'(dut.offset_q), 32'd0);
    check("scr_d11", 32'(segm), 32'(seg_of(11)));
    dig_idx = 4'd0;
    scroll_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      repeat (3) tick();
      check("scr_pre_step", 32'(dut.offset_q), 32'(k - 1));
      tick();
      check("scr_step", 32'(dut.offset_q), 32'(k % 15));
      check("scr_d0", 32'(segm), (k - 1 == 14) ? 32'd0 : 32'(seg_of(k - 1)));
    end
    tick(); tick();
    scroll_en = 1'b0;
    repeat (10) tick();
    check("pause_timer", 32'(dut.timer_q), 32'd2);
    check("pause_off", 32'(dut.offset_q), 32'd0);

    scroll_en = 1'b1;
    tick();
    put(8'h74, 1'b0);
    scroll_en = 1'b0;
    check("coll_state", 32'(dut.state_q), ST_LOAD);
    check("coll_off", 32'(dut.offset_q), 32'd0);
    check("coll_len", 32'(msg_len), 32'd0);
    for (int d = 0; d < 12; d++) begin
      dig_idx = 4'(d);
      tick();
      check("coll_blank", 32'(segm), 32'd0);
    end

    put(8'h6F, 1'b0);
    put(8'h73, 1'b0);
    check("mid_ptr", 32'(dut.wr_ptr_q), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_segm", 32'(segm), 32'd0);
    check("mid_rst_len", 32'(msg_len), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), ST_EMPTY);
    check("mid_rst_ptr", 32'(dut.wr_ptr_q), 32'd0);
    tick();
    rst_n = 1'b1;
    put(8'h73, 1'b1);
    check("s_len", 32'(msg_len), 32'd1);
    dig_idx = 4'd0; tick(); check("s_d0", 32'(segm), 32'(SEG_S));
    dig_idx = 4'd1; tick(); check("s_d1", 32'(segm), 32'd0);
    dig_idx = 4'd0; tick(); check("s_d0_again", 32'(segm), 32'(SEG_S));
    #3 rst_n = 1'b0;
    #1;
    check("show_rst_segm", 32'(segm), 32'd0);
    check("show_rst_len", 32'(msg_len), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      put(char_of(i), 1'b0);
      if (i == 30) begin
        check("full_len_31", 32'(msg_len), 32'd0);
        check("full_state_31", 32'(dut.state_q), ST_LOAD);
      end
    end
    check("full_len", 32'(msg_len), 32'd32);
    check("full_state", 32'(dut.state_q), ST_SHOW);
    dig_idx = 4'd11; tick(); check("full_d11", 32'(segm), 32'(seg_of(11)));
    dig_idx = 4'd12; tick(); check("full_d12", 32'(segm), 32'd0);
    dig_idx = 4'd0;  tick(); check("full_d0", 32'(segm), 32'(SEG_E));
    put(8'h78, 1'b0);
    check("w33_state", 32'(dut.state_q), ST_LOAD);
    check("w33_len", 32'(msg_len), 32'd0);
    check("w33_ptr", 32'(dut.wr_ptr_q), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
